// File: rtl/fp_exp_adder_pipe.sv
// fp_exp_adder_pipe: 2-stage valid/ready exponent adder (exp_a + exp_b + norm_inc - BIAS).
// Define FP_EXP_ADD_SAT_EN to saturate exp_out on ovf/unf. Rev 1.0
`default_nettype none

module fp_exp_adder_pipe #(
  parameter int EW   = 8,
  parameter int BIAS = 2**(EW-1)-1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [EW-1:0] exp_a,
  input  logic [EW-1:0] exp_b,
  input  logic          norm_inc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [EW-1:0] exp_out,
  output logic          ovf,
  output logic          unf,
  output logic          zero
);

  localparam int SW = EW + 2;
  localparam logic signed [SW-1:0] BIAS_S = SW'(BIAS);
  localparam logic signed [SW-1:0] TOP_S  = SW'((2**EW) - 1);

  logic          s1_valid_q, s1_valid_d;
  logic [SW-1:0] sum1_q, sum1_d;
  logic          zero1_q, zero1_d;
  logic          out_valid_q, out_valid_d;
  logic [EW-1:0] exp_out_q, exp_out_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          zero_q, zero_d;

  logic                 s1_load;
  logic                 s2_load;
  logic signed [SW-1:0] raw;
  logic                 ovf_c;
  logic                 unf_c;
  logic [EW-1:0]        exp_c;

  always_comb begin
    s2_load  = s1_valid_q && (!out_valid_q || out_ready);
    in_ready = !s1_valid_q || s2_load;
    s1_load  = in_valid && in_ready;

    s1_valid_d = s1_valid_q;
    sum1_d     = sum1_q;
    zero1_d    = zero1_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
      sum1_d     = SW'(exp_a) + SW'(exp_b) + SW'(norm_inc);
      zero1_d    = (exp_a == '0) || (exp_b == '0);
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    // Sum never exceeds 2**(EW+1)-1, so EW+2 signed bits hold raw exactly.
    raw   = $signed(sum1_q) - BIAS_S;
    ovf_c = !zero1_q && (raw >= TOP_S);
    unf_c = !zero1_q && (raw[SW-1] || (raw == '0));
    if (zero1_q) begin
      exp_c = '0;
    end else begin
`ifdef FP_EXP_ADD_SAT_EN
      if (ovf_c)      exp_c = '1;
      else if (unf_c) exp_c = '0;
      else            exp_c = raw[EW-1:0];
`else
      exp_c = raw[EW-1:0];
`endif
    end

    out_valid_d = out_valid_q;
    exp_out_d   = exp_out_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    zero_d      = zero_q;
    if (s2_load) begin
      out_valid_d = 1'b1;
      exp_out_d   = exp_c;
      ovf_d       = ovf_c;
      unf_d       = unf_c;
      zero_d      = zero1_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      sum1_q      <= '0;
      zero1_q     <= 1'b0;
      out_valid_q <= 1'b0;
      exp_out_q   <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      sum1_q      <= sum1_d;
      zero1_q     <= zero1_d;
      out_valid_q <= out_valid_d;
      exp_out_q   <= exp_out_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign exp_out   = exp_out_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign zero      = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_exp_adder_pipe.sv
// Self-checking bench for fp_exp_adder_pipe (EW=8, BIAS=127); honours FP_EXP_ADD_SAT_EN.
`default_nettype none

module tb_fp_exp_adder_pipe;

  typedef struct packed {
    logic [7:0] e;
    logic       o;
    logic       u;
    logic       z;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] exp_a = '0;
  logic [7:0] exp_b = '0;
  logic       norm_inc = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] exp_out;
  logic       ovf;
  logic       unf;
  logic       zero;

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  res_t exp_q[$];

  bit   stalled = 1'b0;
  res_t held;

  fp_exp_adder_pipe #(.EW(8), .BIAS(127)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .exp_a(exp_a), .exp_b(exp_b), .norm_inc(norm_inc),
    .out_valid(out_valid), .out_ready(out_ready),
    .exp_out(exp_out), .ovf(ovf), .unf(unf), .zero(zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the product exponent.
  function automatic res_t model(input int a, input int b, input int inc);
    res_t r;
    int   raw;
    r   = '0;
    raw = a + b + inc - 127;
    if (a == 0 || b == 0) begin
      r.z = 1'b1;
    end else begin
      r.o = (raw >= 255);
      r.u = (raw <= 0);
`ifdef FP_EXP_ADD_SAT_EN
      if (r.o)      r.e = 8'd255;
      else if (r.u) r.e = 8'd0;
      else          r.e = 8'(((raw % 256) + 256) % 256);
`else
      r.e = 8'(((raw % 256) + 256) % 256);
`endif
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Compare process: handshakes evaluated mid-cycle, inputs change just after posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stalled && out_valid)
        chk("stall_hold", {exp_out, ovf, unf, zero}, held);
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("result", {exp_out, ovf, unf, zero}, e);
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(exp_a, exp_b, norm_inc));
      stalled = out_valid && !out_ready;
      held    = {exp_out, ovf, unf, zero};
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic inc, input bit rnd);
    bit acc;
    in_valid = 1'b1; exp_a = a; exp_b = b; norm_inc = inc;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      if (acc) break;
      if (n > 200) begin
        chk("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  task automatic idle(input int n, input bit rnd);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // One beat on an empty pipe: check latency and the hand-computed result.
  task automatic directed(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic inc, input res_t req);
    int waits;
    out_ready = 1'b1;
    send(a, b, inc, 1'b0);
    in_valid = 1'b0;
    waits = 0;
    @(negedge clk);
    while (!out_valid && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    chk({name, "_latency"}, waits, 1);
    chk(name, {exp_out, ovf, unf, zero}, req);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc;
    int base;
    res_t r;

    // Pin the model to hand-computed values.
    r = model(130, 127, 0); chk("model_nominal", r, {8'd130, 3'b000});
    r = model(64, 64, 0);   chk("model_one", r, {8'd1, 3'b000});
    r = model(0, 200, 1);   chk("model_zero", r, {8'd0, 3'b001});

    #12;
    chk("reset_state", {out_valid, exp_out, ovf, unf, zero, in_ready}, {1'b0, 8'd0, 3'b000, 1'b1});
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", in_ready, 1'b1);

    directed("nominal",     8'd130, 8'd127, 1'b0, {8'd130, 3'b000});
    directed("nominal_inc", 8'd130, 8'd127, 1'b1, {8'd131, 3'b000});
`ifdef FP_EXP_ADD_SAT_EN
    directed("ovf",         8'd200, 8'd200, 1'b0, {8'd255, 3'b100});
    directed("ovf_edge",    8'd254, 8'd128, 1'b0, {8'd255, 3'b100});
    directed("unf",         8'd50,  8'd60,  1'b0, {8'd0,   3'b010});
    directed("unf_edge",    8'd64,  8'd63,  1'b0, {8'd0,   3'b010});
`else
    directed("ovf",         8'd200, 8'd200, 1'b0, {8'd17,  3'b100});
    directed("ovf_edge",    8'd254, 8'd128, 1'b0, {8'd255, 3'b100});
    directed("unf",         8'd50,  8'd60,  1'b0, {8'd239, 3'b010});
    directed("unf_edge",    8'd64,  8'd63,  1'b0, {8'd0,   3'b010});
`endif
    directed("min_normal",  8'd64,  8'd64,  1'b0, {8'd1,   3'b000});
    directed("zero_a",      8'd0,   8'd200, 1'b0, {8'd0,   3'b001});
    directed("zero_b",      8'd255, 8'd0,   1'b1, {8'd0,   3'b001});

    // Back-pressure: 2 beats fill the pipe, then in_ready must drop.
    out_ready = 1'b0;
    base = out_cnt;
    acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_a = 8'(100 + acc); exp_b = 8'(90 + acc); norm_inc = acc[0];
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    chk("bp_accepted", acc, 2);
    chk("bp_in_ready_low", in_ready, 1'b0);
    out_ready = 1'b1;
    send(8'd102, 8'd92, 1'b0, 1'b0);
    send(8'd103, 8'd93, 1'b1, 1'b0);
    drain();
    chk("bp_out_count", out_cnt - base, 4);

    // Full throughput: back-to-back beats never wait with out_ready high.
    base = out_cnt;
    acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_a = 8'($urandom_range(1, 254)); exp_b = 8'($urandom_range(1, 254));
      norm_inc = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    chk("throughput", acc, 8);
    drain();
    chk("throughput_out", out_cnt - base, 8);

    // Randomised traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'b1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 1'b1);
    end
    drain();

    // Reset with two beats in flight: nothing stale may come out afterwards.
    out_ready = 1'b0;
    send(8'd130, 8'd127, 1'b0, 1'b0);
    send(8'd140, 8'd127, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("reset_mid_outvalid", out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("reset_mid_ready", {out_valid, in_ready}, 2'b01);
    base = out_cnt;
    idle(5, 1'b0);
    chk("no_stale_output", out_cnt - base, 0);
    directed("post_reset", 8'd130, 8'd127, 1'b1, {8'd131, 3'b000});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
